// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and helpers for the DES byte-stream controller
package des_pkg;

    localparam int BLOCK_BYTES = 8;
    localparam logic [2:0] LAST_BYTE = 3'(BLOCK_BYTES - 1);

    typedef logic [63:0] des_block_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } des_state_t;

    // Byte 0 is the most significant byte (DES bits 1..8).
    function automatic logic [7:0] get_byte(des_block_t blk, logic [2:0] idx);
        return blk[{~idx, 3'b000} +: 8];
    endfunction

    function automatic des_block_t put_byte(des_block_t blk, logic [2:0] idx, logic [7:0] data);
        des_block_t res;
        res = blk;
        res[{~idx, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/des_stream_ctrl.sv
// rtl/des_stream_ctrl.sv - byte-stream front end that feeds 64-bit blocks to an external DES core
module des_stream_ctrl
    import des_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        core_start,
    output logic [63:0] core_din,
    output logic [63:0] core_key,
    input  logic        core_ready,
    input  logic [63:0] core_dout,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    des_state_t        state_q;
    des_state_t        state_d;
    logic [2:0]        idx_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    des_block_t        block_q;
    des_block_t        key_q;
    des_block_t        out_reg_q;
    logic              timeout_q;

    logic wait_expired;
    assign wait_expired = (wait_cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (in_valid && idx_q == LAST_BYTE) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            // core_ready is only trusted here; a level left over from the previous block is ignored in START
            ST_WAIT: begin
                if (core_ready)        state_d = ST_DRAIN;
                else if (wait_expired) state_d = ST_FILL;
            end
            ST_DRAIN: if (out_ready && idx_q == LAST_BYTE) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            wait_cnt_q <= '0;
            block_q    <= '0;
            key_q      <= '0;
            out_reg_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_valid) begin
                        block_q <= put_byte(block_q, idx_q, in_data);
                        if (idx_q == 3'd0) key_q <= key_in;
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_START: wait_cnt_q <= '0;
                ST_WAIT: begin
                    if (core_ready) begin
                        out_reg_q <= core_dout;
                    end else if (wait_expired) begin
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: if (out_ready) idx_q <= idx_q + 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q == ST_FILL);
        core_start = (state_q == ST_START);
        out_valid  = (state_q == ST_DRAIN);
        out_last   = (state_q == ST_DRAIN) && (idx_q == LAST_BYTE);
        out_data   = (state_q == ST_DRAIN) ? get_byte(out_reg_q, idx_q) : 8'h00;
        busy       = (state_q != ST_FILL) || (idx_q != 3'd0);
    end

    assign core_din    = block_q;
    assign core_key    = key_q;
    assign timeout_err = timeout_q;

endmodule
